// File: rtl/wrp_shff_tok_ctrl_pkg.sv
// Shared constants and helpers for the shuffle-buffer token controller.
package wrp_shff_tok_ctrl_pkg;

  localparam int unsigned DefNch      = 2;
  localparam int unsigned DefBufBlks  = 1024;
  localparam int unsigned DefRGrp     = 32;
  localparam int unsigned DefAfThr    = 16;
  localparam int unsigned DefLastBlks = 32;
  localparam int unsigned DefRdPerWr  = 32;

  // Ceiling log2; clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max1(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/wrp_shff_tok_chan.sv
// One buffer channel: write/read block counters, write and read token pools, flags and
// sticky error bits.
module wrp_shff_tok_chan
  import wrp_shff_tok_ctrl_pkg::*;
#(
  parameter int unsigned BUF_BLKS  = DefBufBlks,
  parameter int unsigned R_GRP     = DefRGrp,
  parameter int unsigned AF_THR    = DefAfThr,
  parameter int unsigned LAST_BLKS = DefLastBlks,
  parameter int unsigned RD_PER_WR = DefRdPerWr,
  parameter int unsigned TOK_W     = clog2(BUF_BLKS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wdone,
  input  logic             rdone,
  input  logic             err_clr,
  output logic             af,
  output logic             empty,
  output logic             err_ovf,
  output logic             err_udf,
  output logic [TOK_W-1:0] w_tok
);

  localparam int unsigned WcntW = max1(clog2(BUF_BLKS));
  localparam int unsigned RcntW = max1(clog2(R_GRP));
  localparam int unsigned RtokW = max1(clog2(LAST_BLKS * RD_PER_WR + 1));

  localparam logic [WcntW-1:0] WcntMax    = WcntW'(BUF_BLKS - 1);
  localparam logic [RcntW-1:0] RcntMax    = RcntW'(R_GRP - 1);
  localparam logic [WcntW-1:0] TrailStart = WcntW'(BUF_BLKS - LAST_BLKS);
  localparam logic [TOK_W:0]   WFull      = (TOK_W + 1)'(BUF_BLKS);
  localparam logic [TOK_W:0]   RGrpCredit = (TOK_W + 1)'(R_GRP);
  localparam logic [TOK_W-1:0] AfThr      = TOK_W'(AF_THR);
  localparam logic [RtokW:0]   RdCredit   = (RtokW + 1)'(RD_PER_WR);

  logic [WcntW-1:0] wcnt_q, wcnt_d;
  logic [RcntW-1:0] rcnt_q, rcnt_d;
  logic [TOK_W-1:0] wtok_q, wtok_d;
  logic [RtokW-1:0] rtok_q, rtok_d;
  logic             af_q, af_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             rgrp;
  logic             trail;
  logic             ovf_set;
  logic             udf_set;
  logic [TOK_W:0]   wsum;
  logic [RtokW:0]   rsum;

  assign rgrp  = rdone && (rcnt_q == RcntMax);
  assign trail = (LAST_BLKS != 0) && wdone && (wcnt_q >= TrailStart);

  // One extra bit so credit returns above BUF_BLKS are visible before saturation.
  assign wsum = {1'b0, wtok_q} + (rgrp ? RGrpCredit : '0) - (TOK_W + 1)'(wdone);
  assign rsum = {1'b0, rtok_q} + (trail ? RdCredit : '0) - (RtokW + 1)'(rdone);

  always_comb begin
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    wtok_d  = wsum[TOK_W-1:0];
    rtok_d  = rsum[RtokW-1:0];
    af_d    = (wtok_q < AfThr);
    empty_d = (rtok_q == '0);
    ovf_set = 1'b0;
    udf_set = 1'b0;

    if (wdone) wcnt_d = (wcnt_q == WcntMax) ? '0 : wcnt_q + 1'b1;
    if (rdone) rcnt_d = (rcnt_q == RcntMax) ? '0 : rcnt_q + 1'b1;

    if (wdone && (wtok_q == '0) && !rgrp) begin
      wtok_d  = '0;
      ovf_set = 1'b1;
    end else if (wsum > WFull) begin
      wtok_d  = WFull[TOK_W-1:0];
      ovf_set = 1'b1;
    end

    if (rdone && (rtok_q == '0) && !trail) begin
      rtok_d  = '0;
      udf_set = 1'b1;
    end else if (rsum[RtokW]) begin
      rtok_d = '1;
    end

    if (flush) begin
      wcnt_d  = '0;
      rcnt_d  = '0;
      wtok_d  = WFull[TOK_W-1:0];
      rtok_d  = '0;
      af_d    = 1'b0;
      empty_d = 1'b1;
      ovf_set = 1'b0;
      udf_set = 1'b0;
    end

    ovf_d = err_clr ? 1'b0 : (ovf_q | ovf_set);
    udf_d = err_clr ? 1'b0 : (udf_q | udf_set);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      wtok_q  <= WFull[TOK_W-1:0];
      rtok_q  <= '0;
      af_q    <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      wtok_q  <= wtok_d;
      rtok_q  <= rtok_d;
      af_q    <= af_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign af      = af_q;
  assign empty   = empty_q;
  assign err_ovf = ovf_q;
  assign err_udf = udf_q;
  assign w_tok   = wtok_q;

endmodule

// File: rtl/wrp_shff_tok_ctrl.sv
// Token controller for NCH independent shuffle buffers; packs per-channel status outputs.
module wrp_shff_tok_ctrl
  import wrp_shff_tok_ctrl_pkg::*;
#(
  parameter int unsigned NCH       = DefNch,
  parameter int unsigned BUF_BLKS  = DefBufBlks,
  parameter int unsigned R_GRP     = DefRGrp,
  parameter int unsigned AF_THR    = DefAfThr,
  parameter int unsigned LAST_BLKS = DefLastBlks,
  parameter int unsigned RD_PER_WR = DefRdPerWr,
  localparam int unsigned TOK_W    = clog2(BUF_BLKS) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       flush,
  input  logic [NCH-1:0]       buf_wdone,
  input  logic [NCH-1:0]       buf_rdone,
  input  logic                 err_clr,
  output logic [NCH-1:0]       buf_af,
  output logic [NCH-1:0]       buf_empty,
  output logic [NCH-1:0]       err_ovf,
  output logic [NCH-1:0]       err_udf,
  output logic [NCH*TOK_W-1:0] w_lvl
);

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    wrp_shff_tok_chan #(
      .BUF_BLKS  (BUF_BLKS),
      .R_GRP     (R_GRP),
      .AF_THR    (AF_THR),
      .LAST_BLKS (LAST_BLKS),
      .RD_PER_WR (RD_PER_WR),
      .TOK_W     (TOK_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush[c]),
      .wdone   (buf_wdone[c]),
      .rdone   (buf_rdone[c]),
      .err_clr (err_clr),
      .af      (buf_af[c]),
      .empty   (buf_empty[c]),
      .err_ovf (err_ovf[c]),
      .err_udf (err_udf[c]),
      .w_tok   (w_lvl[c*TOK_W +: TOK_W])
    );
  end

endmodule

// File: tb/tb_wrp_shff_tok_ctrl.sv
// Directed bench for wrp_shff_tok_ctrl: token-pool model checked every cycle plus literal checks.
module tb_wrp_shff_tok_ctrl;

  localparam int NCH       = 2;
  localparam int BUF_BLKS  = 1024;
  localparam int R_GRP     = 32;
  localparam int AF_THR    = 16;
  localparam int LAST_BLKS = 32;
  localparam int RD_PER_WR = 32;
  localparam int TOK_W     = 11;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NCH-1:0]       flush = '0;
  logic [NCH-1:0]       wd = '0;
  logic [NCH-1:0]       rd = '0;
  logic                 err_clr = 1'b0;
  logic [NCH-1:0]       buf_af, buf_empty, err_ovf, err_udf;
  logic [NCH*TOK_W-1:0] w_lvl;

  int n_chk  = 0;
  int n_fail = 0;

  wrp_shff_tok_ctrl #(
    .NCH       (NCH),
    .BUF_BLKS  (BUF_BLKS),
    .R_GRP     (R_GRP),
    .AF_THR    (AF_THR),
    .LAST_BLKS (LAST_BLKS),
    .RD_PER_WR (RD_PER_WR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .buf_wdone (wd),
    .buf_rdone (rd),
    .err_clr   (err_clr),
    .buf_af    (buf_af),
    .buf_empty (buf_empty),
    .err_ovf   (err_ovf),
    .err_udf   (err_udf),
    .w_lvl     (w_lvl)
  );

  always #5 clk = ~clk;

  // Model: token pools as plain integers; flags are last cycle's pool levels.
  int m_wtok[NCH], m_rtok[NCH], m_nw[NCH], m_nr[NCH];
  bit m_af[NCH], m_empty[NCH], m_ovf[NCH], m_udf[NCH];

  task automatic m_step(input int c);
    int wt, rt;
    bit grp, trail, os, us;
    os = 0;
    us = 0;
    if (!rst_n) begin
      m_wtok[c] = BUF_BLKS; m_rtok[c] = 0; m_nw[c] = 0; m_nr[c] = 0;
      m_af[c] = 0; m_empty[c] = 1; m_ovf[c] = 0; m_udf[c] = 0;
      return;
    end
    if (flush[c]) begin
      m_wtok[c] = BUF_BLKS; m_rtok[c] = 0; m_nw[c] = 0; m_nr[c] = 0;
      m_af[c] = 0; m_empty[c] = 1;
    end else begin
      grp   = rd[c] && ((m_nr[c] % R_GRP) == R_GRP - 1);
      trail = wd[c] && ((m_nw[c] % BUF_BLKS) >= BUF_BLKS - LAST_BLKS);
      m_af[c]    = m_wtok[c] < AF_THR;
      m_empty[c] = m_rtok[c] == 0;
      wt = m_wtok[c] + (grp ? R_GRP : 0) - int'(wd[c]);
      if (wt < 0) begin wt = 0; os = 1; end
      if (wt > BUF_BLKS) begin wt = BUF_BLKS; os = 1; end
      rt = m_rtok[c] + (trail ? RD_PER_WR : 0) - int'(rd[c]);
      if (rt < 0) begin rt = 0; us = 1; end
      m_wtok[c] = wt;
      m_rtok[c] = rt;
      m_nw[c] += int'(wd[c]);
      m_nr[c] += int'(rd[c]);
    end
    if (err_clr) begin
      m_ovf[c] = 0;
      m_udf[c] = 0;
    end else begin
      m_ovf[c] = m_ovf[c] | os;
      m_udf[c] = m_udf[c] | us;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int c = 0; c < NCH; c++) m_step(c);
  end

  task automatic chk(input string name, input int c, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s ch%0d: got %0d, expected %0d at %0t", name, c, act, exp, $time);
    end
  endtask

  function automatic int lvl(input int c);
    return int'(w_lvl[c*TOK_W +: TOK_W]);
  endfunction

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        chk("model_w_lvl", c, 32'(lvl(c)), m_wtok[c]);
        chk("model_af", c, 32'(buf_af[c]), int'(m_af[c]));
        chk("model_empty", c, 32'(buf_empty[c]), int'(m_empty[c]));
        chk("model_ovf", c, 32'(err_ovf[c]), int'(m_ovf[c]));
        chk("model_udf", c, 32'(err_udf[c]), int'(m_udf[c]));
      end
    end
  end

  // One clock of stimulus; entered and left at 1 time unit after a rising edge.
  task automatic cyc(input logic [NCH-1:0] w, input logic [NCH-1:0] r,
                     input logic [NCH-1:0] f, input logic ec);
    wd = w; rd = r; flush = f; err_clr = ec;
    @(posedge clk);
    #1;
    wd = '0; rd = '0; flush = '0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc('0, '0, '0, 1'b0);
  endtask

  initial begin
    do_reset();
    chk("rst_w_lvl", 0, 32'(lvl(0)), 1024);
    chk("rst_w_lvl", 1, 32'(lvl(1)), 1024);
    chk("rst_empty", 0, 32'(buf_empty), 3);
    chk("rst_af", 0, 32'(buf_af), 0);

    // Almost-full: flag follows w_tok < 16 with two cycles of latency.
    repeat (1008) cyc(2'b01, '0, '0, 1'b0);
    chk("w_lvl_after_1008", 0, 32'(lvl(0)), 16);
    cyc('0, '0, '0, 1'b0);
    chk("af_at_16", 0, 32'(buf_af[0]), 0);
    cyc(2'b01, '0, '0, 1'b0);
    chk("w_lvl_after_1009", 0, 32'(lvl(0)), 15);
    chk("af_lag", 0, 32'(buf_af[0]), 0);
    cyc('0, '0, '0, 1'b0);
    chk("af_rise", 0, 32'(buf_af[0]), 1);

    // First trailing write releases 32 read tokens.
    do_reset();
    repeat (993) cyc(2'b01, '0, '0, 1'b0);
    chk("empty_lag", 0, 32'(buf_empty[0]), 1);
    cyc('0, '0, '0, 1'b0);
    chk("empty_fall", 0, 32'(buf_empty[0]), 0);
    repeat (31) cyc('0, 2'b01, '0, 1'b0);
    chk("empty_31rd", 0, 32'(buf_empty[0]), 0);
    cyc('0, 2'b01, '0, 1'b0);
    chk("w_lvl_credit", 0, 32'(lvl(0)), 1024 - 993 + 32);
    cyc('0, '0, '0, 1'b0);
    chk("empty_back", 0, 32'(buf_empty[0]), 1);
    chk("no_udf", 0, 32'(err_udf[0]), 0);

    // Write coincident with the credit-returning read nets out.
    do_reset();
    repeat (1019) cyc(2'b01, '0, '0, 1'b0);
    chk("w_lvl_5", 0, 32'(lvl(0)), 5);
    repeat (31) cyc('0, 2'b01, '0, 1'b0);
    cyc(2'b01, 2'b01, '0, 1'b0);
    chk("w_lvl_net", 0, 32'(lvl(0)), 36);
    chk("net_no_ovf", 0, 32'(err_ovf[0]), 0);

    // Underflow on channel 1 and err_clr precedence.
    cyc('0, 2'b10, '0, 1'b0);
    chk("udf_set", 1, 32'(err_udf[1]), 1);
    repeat (2) cyc('0, '0, '0, 1'b0);
    chk("udf_sticky", 1, 32'(err_udf[1]), 1);
    cyc('0, '0, '0, 1'b1);
    chk("udf_clr", 1, 32'(err_udf[1]), 0);
    cyc('0, 2'b10, '0, 1'b1);
    chk("clr_wins", 1, 32'(err_udf[1]), 0);
    cyc('0, 2'b10, '0, 1'b0);
    chk("udf_relatch", 1, 32'(err_udf[1]), 1);
    cyc('0, '0, '0, 1'b1);

    // Excess credit saturates on ch0; writing past zero tokens on ch1.
    do_reset();
    repeat (32) cyc('0, 2'b01, '0, 1'b0);
    chk("sat_w_lvl", 0, 32'(lvl(0)), 1024);
    chk("sat_ovf", 0, 32'(err_ovf[0]), 1);
    chk("sat_udf", 0, 32'(err_udf[0]), 1);
    repeat (1024) cyc(2'b10, '0, '0, 1'b0);
    chk("w_lvl_zero", 1, 32'(lvl(1)), 0);
    chk("no_ovf_yet", 1, 32'(err_ovf[1]), 0);
    cyc(2'b10, '0, '0, 1'b0);
    chk("wr_ovf", 1, 32'(err_ovf[1]), 1);
    chk("wr_ovf_hold", 1, 32'(lvl(1)), 0);

    // Flush channel 1 while channel 0 keeps counting; then asynchronous reset mid-cycle.
    do_reset();
    repeat (40) cyc(2'b11, '0, '0, 1'b0);
    cyc(2'b11, '0, 2'b10, 1'b0);
    chk("flush_w_lvl", 1, 32'(lvl(1)), 1024);
    chk("flush_empty", 1, 32'(buf_empty[1]), 1);
    chk("flush_other", 0, 32'(lvl(0)), 1024 - 41);
    cyc('0, 2'b01, '0, 1'b0);
    chk("pre_rst_udf", 0, 32'(err_udf[0]), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_w_lvl0", 0, 32'(lvl(0)), 1024);
    chk("arst_w_lvl1", 1, 32'(lvl(1)), 1024);
    chk("arst_empty", 0, 32'(buf_empty), 3);
    chk("arst_af", 0, 32'(buf_af), 0);
    chk("arst_udf", 0, 32'(err_udf), 0);
    chk("arst_ovf", 0, 32'(err_ovf), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) cyc(2'b01, '0, '0, 1'b0);
    chk("post_rst_w_lvl", 0, 32'(lvl(0)), 1020);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
